// File: rtl/multu_seq.sv
// Sequential 32x32 unsigned shift-add multiplier (MULTU) with a done/ready handshake toward HI/LO.
// Optional build macro: MULTU_ZERO_SKIP_EN (a zero operand goes straight to DONE with a zero product).
module multu_seq #(
    parameter logic [5:0] MULTU = 6'b011001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    input  logic        start,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [32:0] sum_s;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

    // 32-bit ripple-carry chain of full adders; bit 32 is the final carry.
    function automatic logic [32:0] ripple_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        logic [1:0]  fa;
        logic        c;
        c = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fa   = full_adder(a[i], b[i], c);
            r[i] = fa[0];
            c    = fa[1];
        end
        r[32] = c;
        return r;
    endfunction

    // Upper half of the accumulator plus multiplicand.
    always_comb begin
        sum_s = ripple_add(acc_q[63:32], mcand_q);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                if (start && (Signal == MULTU)) begin
                    mcand_d = dataA;
                    acc_d   = {32'd0, dataB};
                    cnt_d   = 6'd0;
`ifdef MULTU_ZERO_SKIP_EN
                    if ((dataA == 32'd0) || (dataB == 32'd0)) begin
                        state_d   = DONE;
                        product_d = 64'd0;
                        busy_d    = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
`else
                    state_d = RUN;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (acc_q[0]) begin
                    acc_d = {sum_s, acc_q[31:1]};
                end else begin
                    acc_d = {1'b0, acc_q[63:1]};
                end
                cnt_d = cnt_q + 6'd1;
                // Iteration with cnt == 31 is the last; publish the updated accumulator.
                if (cnt_q == 6'd31) begin
                    product_d = acc_d;
                    state_d   = DONE;
                    busy_d    = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= 64'd0;
            mcand_q   <= 32'd0;
            cnt_q     <= 6'd0;
            product_q <= 64'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_multu_seq.sv
// Directed self-checking bench for multu_seq: latency, products, handshake, reset abort, zero operands.
module tb_multu_seq;

    localparam logic [5:0] MULTU_FN = 6'b011001;
    localparam logic [5:0] ADD_FN   = 6'b100000;
    localparam logic [5:0] SUB_FN   = 6'b100010;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic        start;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_checks;
    int n_pass;
    int lat;

    multu_seq dut (
        .clk       (clk),
        .reset     (reset),
        .dataA     (dataA),
        .dataB     (dataB),
        .Signal    (Signal),
        .start     (start),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one edge, then scramble the operands to prove they were captured.
    task automatic request(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
        dataA  = a;
        dataB  = b;
        Signal = fn;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        dataA  = 32'hA5A5_5A5A;
        dataB  = 32'h3C3C_C3C3;
    endtask

    // Cycle index of the first cycle showing done (acceptance edge = cycle 0); 40 means timeout.
    task automatic wait_done(output int l);
        l = 1;
        while (!done && l < 40) begin
            tick();
            l++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        Signal    = 6'd0;
        dataA     = 32'd0;
        dataB     = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);

        // 3 x 5 with immediate acceptance downstream
        out_ready = 1'b1;
        request(32'd3, 32'd5, MULTU_FN);
        check("3x5_busy_c1", {63'd0, busy}, 64'd1);
        check("3x5_done_c1", {63'd0, done}, 64'd0);
        wait_done(lat);
        check("3x5_latency", 64'(lat), 64'd33);
        check("3x5_product", product, 64'h0000_0000_0000_000F);
        tick();
        check("3x5_idle_busy", {63'd0, busy}, 64'd0);
        check("3x5_idle_done", {63'd0, done}, 64'd0);

        // Back-to-back at cycle 34: all-ones operands, carry every iteration
        request(32'hFFFF_FFFF, 32'hFFFF_FFFF, MULTU_FN);
        check("ff_busy_c1", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check("ff_latency", 64'(lat), 64'd33);
        check("ff_product", product, 64'hFFFF_FFFE_0000_0001);
        tick();

        // Non-MULTU function codes are ignored
        request(32'd6, 32'd7, ADD_FN);
        check("add_busy", {63'd0, busy}, 64'd0);
        check("add_product", product, 64'hFFFF_FFFE_0000_0001);
        request(32'd6, 32'd7, SUB_FN);
        check("sub_busy", {63'd0, busy}, 64'd0);
        check("sub_product", product, 64'hFFFF_FFFE_0000_0001);

        // Reset at cycle 10 aborts 7 x 9
        request(32'd7, 32'd9, MULTU_FN);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        request(32'd2, 32'd2, MULTU_FN);
        wait_done(lat);
        check("2x2_latency", 64'(lat), 64'd33);
        check("2x2_product", product, 64'h4);
        tick();

        // 12 x 12 held in DONE while start pulses are ignored
        out_ready = 1'b0;
        request(32'd12, 32'd12, MULTU_FN);
        wait_done(lat);
        check("12x12_latency", 64'(lat), 64'd33);
        for (int i = 0; i < 20; i++) begin
            dataA  = 32'd1;
            dataB  = 32'd1;
            Signal = MULTU_FN;
            start  = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check("hold_done", {63'd0, done}, 64'd1);
            check("hold_product", product, 64'h90);
        end
        // start and out_ready in the same DONE cycle: exit without accepting
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("exit_busy", {63'd0, busy}, 64'd0);
        check("exit_done", {63'd0, done}, 64'd0);
        check("exit_product", product, 64'h90);
        tick();
        check("no_accept_busy", {63'd0, busy}, 64'd0);

        // Zero operand
        request(32'd0, 32'h1234_5678, MULTU_FN);
        check("zero_busy_c1", {63'd0, busy}, 64'd1);
        wait_done(lat);
`ifdef MULTU_ZERO_SKIP_EN
        check("zero_latency", 64'(lat), 64'd1);
`else
        check("zero_latency", 64'(lat), 64'd33);
`endif
        check("zero_product", product, 64'd0);
        tick();
        check("zero_idle_busy", {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
